cflog_reader: RTL
=================

Name: cflog_reader

Overview:
- Read-side counterpart of the CFLog writer path (log monitor driving hw_wen/log_ptr).
- On a flush request or ER completion, freezes the current CFLog fill level and walks the CFLog memory through a read port. Streams a header word followed by every logged word over a valid/ready word interface to the attestation transmitter.
- Afterwards, pulses a clear to the log monitor so logging restarts at slot 0.

Parameters:
- LOG_SIZE, 16'h80, CFLog capacity in 2-byte words; captured counts are clamped to this.
- LOG_BASE, 16'h0600, byte address of CFLog word 0; word i is at LOG_BASE + 2*i.

Ports:
- clk  input  1  system clock, all logic on rising edge
- puc_n  input  1  asynchronous active-low reset
- flush  input  1  log-full flush request from the log monitor (level)
- er_done  input  1  ER exit indication (level)
- cflow_log_ptr  input  16  number of CFLog words currently written
- log_rd_en  output  1  CFLog read strobe, one cycle per word
- log_rd_addr  output  16  CFLog byte read address
- log_rd_data  input  16  read data, valid exactly 1 cycle after log_rd_en
- tx_data  output  16  stream word
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  downstream accepts word
- tx_last  output  1  marks final word of a drain
- busy  output  1  drain in progress; the log monitor holds writes while high
- log_clr  output  1  one-cycle pulse: reset CFLog pointer to 0
- drain_done  output  1  one-cycle pulse coincident with log_clr

Behaviour:
- Reset (puc_n=0, async):
  - State goes to IDLE.
  - All outputs go to 0.
  - The pending flag, edge-detect register, count and index registers all clear.
- Trigger:
  - trig = flush | er_done.
  - A start is a rising edge of trig, detected against a registered copy of trig.
  - A start seen in IDLE enters HDR on the next cycle.
  - A start seen while busy sets pending. On return to IDLE with pending set, the block clears pending and enters HDR on the next cycle.
- Capture on leaving IDLE:
  - count = min(cflow_log_ptr, LOG_SIZE).
  - ovf = (cflow_log_ptr > LOG_SIZE).
  - cause = er_done sampled at the start edge.
  - idx = 0.
- States:
  - IDLE: busy=0, tx_valid=0.
  - HDR:
    - tx_data = {ovf, cause, count[13:0]}, tx_valid=1.
    - tx_last = (count==0).
    - On tx_ready: count==0 goes to CLEAR, else to FETCH.
  - FETCH:
    - log_rd_en=1 for one cycle, log_rd_addr = LOG_BASE + {idx[14:0],1'b0}.
    - Next state CAPT.
  - CAPT: latch log_rd_data into tx_data, go to SEND.
  - SEND:
    - tx_valid=1, tx_last = (idx == count-1).
    - On tx_ready: idx increments; last word goes to CLEAR, else to FETCH.
  - CLEAR: log_clr=1 and drain_done=1 for one cycle, then IDLE.
- busy = 1 in all states except IDLE, including CLEAR.
- Handshake:
  - A transfer occurs when tx_valid & tx_ready.
  - tx_data and tx_last are held stable while tx_valid & !tx_ready.
  - tx_valid never drops without a transfer.
  - tx_ready asserted while tx_valid=0 has no effect.
- Throughput: 3 cycles per payload word minimum (FETCH, CAPT, SEND with ready=1). Header takes 1 cycle with ready=1.
- Widths:
  - log_rd_addr wraps modulo 2^16; the integrator places LOG_BASE so no wrap occurs.
  - idx is 16 bits; count never exceeds LOG_SIZE.
- cflow_log_ptr changes after capture are ignored until the next drain.
- flush and er_done rising in the same cycle form one start, with cause=1.
- Reset mid-drain aborts immediately: no log_clr pulse and no partial last word.

Test Plan:
- Reset, then cflow_log_ptr=3, flush 0->1, tx_ready=1 constant:
  - Stream is 16'h0003, then words at LOG_BASE+0, +2, +4.
  - tx_last is set only on the third payload word.
  - log_clr pulses once, 1 cycle after the last transfer.
  - Total 11 cycles from HDR entry to CLEAR.
- er_done rise with cflow_log_ptr=0: single word 16'h4000 with tx_last=1, then log_clr pulse.
- cflow_log_ptr=16'h0090 with LOG_SIZE=16'h80, flush rise:
  - Header is 16'h8080.
  - Exactly 128 payload words are sent; last address is LOG_BASE+16'h00FE.
- tx_ready held low 5 cycles during the second payload word (value 16'hBEEF): tx_data=16'hBEEF and tx_valid=1 stay stable for all 5 cycles, and exactly one transfer occurs.
- Second flush rise during a drain: the current drain completes, then pending causes a second header the cycle after IDLE, with count re-captured from cflow_log_ptr.
- puc_n asserted mid-SEND: all outputs are 0 asynchronously and no log_clr pulse occurs. After release, no drain starts until a new trig rising edge.

Source files
------------

// File: rtl/cflog_reader.sv
`default_nettype none
// ============================================================================
//  Module      : cflog_reader
//  Description : Drains the CFLog memory on a flush request or ER exit. Sends
//                a header word followed by every logged word over a
//                valid/ready word stream, then pulses a clear to the log
//                monitor so logging restarts at slot 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module cflog_reader #(
    parameter logic [15:0] LOG_SIZE = 16'h0080,
    parameter logic [15:0] LOG_BASE = 16'h0600
) (
    input  logic        clk,
    input  logic        puc_n,
    input  logic        flush,
    input  logic        er_done,
    input  logic [15:0] cflow_log_ptr,
    output logic        log_rd_en,
    output logic [15:0] log_rd_addr,
    input  logic [15:0] log_rd_data,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic        log_clr,
    output logic        drain_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FETCH = 3'd2,
        S_CAPT  = 3'd3,
        S_SEND  = 3'd4,
        S_CLEAR = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        trig_q;
    logic        pend_q, pend_d;
    logic        pcause_q, pcause_d;
    logic        ovf_q, ovf_d;
    logic        cause_q, cause_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] data_q, data_d;

    logic w_trig;
    logic w_start;
    logic w_last;

    assign w_trig  = flush | er_done;
    assign w_start = w_trig & ~trig_q;
    // Last payload word of the drain; only meaningful in SEND where count > 0.
    assign w_last  = (idx_q == (count_q - 16'd1));

    // State and datapath registers; reset aborts any drain without a clear.
    always_ff @(posedge clk or negedge puc_n) begin
        if (!puc_n) begin
            state_q  <= S_IDLE;
            trig_q   <= 1'b0;
            pend_q   <= 1'b0;
            pcause_q <= 1'b0;
            ovf_q    <= 1'b0;
            cause_q  <= 1'b0;
            count_q  <= 16'd0;
            idx_q    <= 16'd0;
            data_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            trig_q   <= w_trig;
            pend_q   <= pend_d;
            pcause_q <= pcause_d;
            ovf_q    <= ovf_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    // Next-state and output decode for the drain sequencer.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pcause_d    = pcause_q;
        ovf_d       = ovf_q;
        cause_d     = cause_q;
        count_d     = count_q;
        idx_d       = idx_q;
        data_d      = data_q;
        log_rd_en   = 1'b0;
        log_rd_addr = 16'd0;
        tx_data     = 16'd0;
        tx_valid    = 1'b0;
        tx_last     = 1'b0;
        log_clr     = 1'b0;
        drain_done  = 1'b0;
        busy        = (state_q != S_IDLE);

        // A start arriving mid-drain is remembered, with its cause, and
        // served once the current drain has returned to IDLE.
        if (w_start && (state_q != S_IDLE)) begin
            pend_d   = 1'b1;
            pcause_d = er_done;
        end

        case (state_q)
            S_IDLE: begin
                if (w_start || pend_q) begin
                    state_d = S_HDR;
                    pend_d  = 1'b0;
                    ovf_d   = (cflow_log_ptr > LOG_SIZE);
                    count_d = (cflow_log_ptr > LOG_SIZE) ? LOG_SIZE : cflow_log_ptr;
                    cause_d = w_start ? er_done : pcause_q;
                    idx_d   = 16'd0;
                end
            end
            S_HDR: begin
                tx_data  = {ovf_q, cause_q, count_q[13:0]};
                tx_valid = 1'b1;
                tx_last  = (count_q == 16'd0);
                if (tx_ready) begin
                    state_d = (count_q == 16'd0) ? S_CLEAR : S_FETCH;
                end
            end
            S_FETCH: begin
                log_rd_en   = 1'b1;
                log_rd_addr = LOG_BASE + {idx_q[14:0], 1'b0};
                state_d     = S_CAPT;
            end
            S_CAPT: begin
                data_d  = log_rd_data;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_data  = data_q;
                tx_valid = 1'b1;
                tx_last  = w_last;
                if (tx_ready) begin
                    idx_d   = idx_q + 16'd1;
                    state_d = w_last ? S_CLEAR : S_FETCH;
                end
            end
            S_CLEAR: begin
                log_clr    = 1'b1;
                drain_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
